// File: rtl/sampling_pkg.sv
// Frame geometry and pixel types shared by the 2x upsampler and downsampler.
package sampling_pkg;

    localparam int FRAME_IN_WIDTH   = 800;
    localparam int FRAME_IN_HEIGHT  = 600;
    localparam int FRAME_OUT_WIDTH  = FRAME_IN_WIDTH / 2;
    localparam int FRAME_OUT_HEIGHT = FRAME_IN_HEIGHT / 2;
    localparam int FRAME_CNT_W      = 10;
    localparam int PIXEL_W          = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/sum_line_ram.sv
// Line buffer for horizontal pair sums: one write port, one registered read port.
module sum_line_ram
    import sampling_pkg::*;
#(
    parameter int DEPTH  = FRAME_OUT_WIDTH,
    parameter int WIDTH  = PIXEL_W + 1,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Read data only updates on a read, so it survives gaps in the input stream.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/downsampler_2x.sv
// 2x2 block-average decimator: raster pixel stream in, rounded block means out to a FIFO.
module downsampler_2x
    import sampling_pkg::*;
#(
    parameter int IN_WIDTH  = FRAME_IN_WIDTH,
    parameter int IN_HEIGHT = FRAME_IN_HEIGHT,
    parameter int DATA_W    = PIXEL_W,
    parameter int CNT_W     = FRAME_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic              fifo_full,
    output logic [CNT_W-1:0]  current_rowcount,
    output logic [CNT_W-1:0]  current_colcount,
    output logic              fifo_write,
    output logic [DATA_W-1:0] dataout,
    output logic              frame_done,
    output logic              overflow
);

    localparam int HALF_W = IN_WIDTH / 2;
    localparam int ADDR_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [CNT_W-1:0]  r_col;
    logic [CNT_W-1:0]  r_row;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_dataout;
    logic              r_fifo_write;
    logic              r_frame_done;
    logic              r_overflow;

    logic              w_col_last;
    logic              w_row_last;
    logic              w_odd_col;
    logic              w_odd_row;
    logic [ADDR_W-1:0] w_pair_addr;
    logic [DATA_W:0]   w_hsum;
    logic [DATA_W:0]   w_rd_data;
    logic [DATA_W+1:0] w_total;
    logic [DATA_W-1:0] w_avg;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_out_due;

    assign w_col_last  = (r_col == CNT_W'(IN_WIDTH - 1));
    assign w_row_last  = (r_row == CNT_W'(IN_HEIGHT - 1));
    assign w_odd_col   = r_col[0];
    assign w_odd_row   = r_row[0];
    assign w_pair_addr = r_col[ADDR_W:1];

    assign w_hsum    = {1'b0, r_hold} + {1'b0, data};
    assign w_wr_en   = valid & ~w_odd_row &  w_odd_col;
    assign w_rd_en   = valid &  w_odd_row & ~w_odd_col;
    assign w_out_due = valid &  w_odd_row &  w_odd_col;

    // Max total is 4*(2^DATA_W-1), so the +2 round-half-up never overflows DATA_W+2 bits.
    assign w_total = {1'b0, w_hsum} + {1'b0, w_rd_data};
    assign w_avg   = DATA_W'((w_total + (DATA_W+2)'(2)) >> 2);

    sum_line_ram #(
        .DEPTH  (HALF_W),
        .WIDTH  (DATA_W + 1),
        .ADDR_W (ADDR_W)
    ) u_sum_line_ram (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_pair_addr),
        .i_wr_data (w_hsum),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_pair_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= '0;
            r_dataout    <= '0;
            r_fifo_write <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_fifo_write <= 1'b0;
            r_frame_done <= 1'b0;
            if (valid) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (!w_odd_col) begin
                    r_hold <= data;
                end
                r_frame_done <= w_col_last & w_row_last;
                // A full FIFO drops the pixel rather than stalling the stream.
                if (w_out_due) begin
                    r_dataout    <= w_avg;
                    r_fifo_write <= ~fifo_full;
                    if (fifo_full) begin
                        r_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign current_rowcount = r_row;
    assign current_colcount = r_col;
    assign fifo_write       = r_fifo_write;
    assign dataout          = r_dataout;
    assign frame_done       = r_frame_done;
    assign overflow         = r_overflow;

endmodule
